// File: rtl/async_fifo_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and full / almost-full / level / sticky-overflow flags.
`timescale 1ns/1ps
module async_fifo_wptr_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gray_async,
    input  logic                  ovf_clr,
    output logic                  wr_ram_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] rq, rbin;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic          accept;

    assign rq     = sync_q[SYNC_STAGES-1];
    assign accept = wr_en & ~full_q;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_rbin
            assign rbin[gi] = ^rq[PW-1:gi];
        end
    endgenerate

    always_comb begin
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        // Full when the write pointer is exactly one lap ahead of the visible read pointer.
        full_d  = (wgray_d == {~rq[PW-1:PW-2], rq[PW-3:0]});
        level_d = wbin_d - rbin;
        af_d    = (level_d >= AF_THRESH);
        ovf_d   = (wr_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rd_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            af_q    <= af_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_ram_en   = accept;
    assign wr_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wr_gray     = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Bench for async_fifo_wptr_ctrl: occupancy-level model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_async_fifo_wptr_ctrl;
    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int AFL   = 14;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          ovf_clr;
    logic [AW:0]   rd_gray_async;
    logic          wr_ram_en;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_level;
    logic          overflow;

    async_fifo_wptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .AF_LEVEL(AFL)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_gray_async(rd_gray_async),
        .ovf_clr(ovf_clr), .wr_ram_en(wr_ram_en), .wr_addr(wr_addr), .wr_gray(wr_gray),
        .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int v);
        logic [4:0] x;
        x = v[4:0];
        return int'(x ^ (x >> 1));
    endfunction

    function automatic int from_gray(input logic [4:0] g);
        for (int x = 0; x < PMOD; x++) begin
            if (to_gray(x) == int'(g)) return x;
        end
        return 0;
    endfunction

    // Model: count of accepted writes, and the read count visible after the synchroniser delay.
    int m_wcnt = 0;
    int m_level = 0;
    bit m_full = 1'b0;
    bit m_af = 1'b0;
    bit m_ovf = 1'b0;
    int m_samp [SS];
    int m_acc;
    int m_lvl_next;

    always_comb begin
        m_acc      = 0;
        m_lvl_next = 0;
        m_acc      = (wr_en && !m_full) ? 1 : 0;
        m_lvl_next = (((m_wcnt + m_acc) % PMOD) - m_samp[SS-1] + PMOD) % PMOD;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wcnt  <= 0;
            m_level <= 0;
            m_full  <= 1'b0;
            m_af    <= 1'b0;
            m_ovf   <= 1'b0;
            for (int i = 0; i < SS; i++) m_samp[i] <= 0;
        end else begin
            m_wcnt  <= (m_wcnt + m_acc) % PMOD;
            m_level <= m_lvl_next;
            m_full  <= (m_lvl_next == DEPTH);
            m_af    <= (m_lvl_next >= AFL);
            m_ovf   <= (wr_en && m_full) || (m_ovf && !ovf_clr);
            m_samp[0] <= from_gray(rd_gray_async);
            for (int i = 1; i < SS; i++) m_samp[i] <= m_samp[i-1];
        end
    end

    logic [AW:0] prev_gray = '0;
    bit          prev_ok = 1'b0;

    always @(negedge clk) begin
        chk("m_wr_addr", int'(wr_addr), m_wcnt % DEPTH);
        chk("m_wr_gray", int'(wr_gray), to_gray(m_wcnt));
        chk("m_full", int'(full), int'(m_full));
        chk("m_almost_full", int'(almost_full), int'(m_af));
        chk("m_wr_level", int'(wr_level), m_level);
        chk("m_overflow", int'(overflow), int'(m_ovf));
        chk("m_wr_ram_en", int'(wr_ram_en), (wr_en && !m_full) ? 1 : 0);
        if (rst_n && prev_ok)
            chk("gray_single_step", ($countones(prev_gray ^ wr_gray) <= 1) ? 1 : 0, 1);
        prev_gray <= wr_gray;
        prev_ok   <= rst_n;
    end

    task automatic cyc(input logic we, input logic [4:0] rg, input logic clr);
        #1;
        wr_en         = we;
        rd_gray_async = rg;
        ovf_clr       = clr;
        @(negedge clk);
    endtask

    logic [4:0] exp_g [4];
    int w;

    initial begin
        exp_g = '{5'h01, 5'h03, 5'h02, 5'h06};
        rst_n = 1'b0;
        wr_en = 1'b1;
        ovf_clr = 1'b0;
        rd_gray_async = 5'h1F;
        repeat (3) @(negedge clk);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_gray", int'(wr_gray), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_level", int'(wr_level), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_ram_en", int'(wr_ram_en), 1);

        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_gray_async = 5'h00;
        @(negedge clk);
        repeat (3) cyc(1'b0, 5'h00, 1'b0);
        chk("idle_wr_addr", int'(wr_addr), 0);
        chk("idle_wr_gray", int'(wr_gray), 0);
        chk("idle_level", int'(wr_level), 0);
        chk("idle_full", int'(full), 0);

        // Fill to full with the read pointer parked at zero.
        for (int k = 1; k <= 16; k++) begin
            chk("fill_addr", int'(wr_addr), k - 1);
            cyc(1'b1, 5'h00, 1'b0);
            if (k <= 4) chk("fill_gray", int'(wr_gray), int'(exp_g[k-1]));
            if (k == 13) chk("af_before", int'(almost_full), 0);
            if (k == 14) chk("af_rise", int'(almost_full), 1);
            if (k == 15) chk("full_before", int'(full), 0);
        end
        chk("full_rise", int'(full), 1);
        chk("full_gray", int'(wr_gray), 5'h18);
        chk("full_level", int'(wr_level), 16);

        // Writes while full.
        repeat (3) begin
            cyc(1'b1, 5'h00, 1'b0);
            chk("ovf_ram_en", int'(wr_ram_en), 0);
            chk("ovf_gray", int'(wr_gray), 5'h18);
            chk("ovf_set", int'(overflow), 1);
        end
        cyc(1'b1, 5'h00, 1'b1);
        chk("ovf_set_wins", int'(overflow), 1);
        cyc(1'b0, 5'h00, 1'b1);
        chk("ovf_cleared", int'(overflow), 0);

        // Drain visibility: read pointer 1 appears after three edges.
        repeat (2) begin
            cyc(1'b0, 5'h01, 1'b0);
            chk("drain_full_hold", int'(full), 1);
            chk("drain_level_hold", int'(wr_level), 16);
        end
        cyc(1'b0, 5'h01, 1'b0);
        chk("drain_full_fall", int'(full), 0);
        chk("drain_level", int'(wr_level), 15);
        chk("drain_af", int'(almost_full), 1);

        // Simultaneous write and visible read advance at level 15.
        repeat (2) begin
            cyc(1'b0, 5'h03, 1'b0);
            chk("sim_pre_level", int'(wr_level), 15);
        end
        cyc(1'b1, 5'h03, 1'b0);
        chk("sim_full", int'(full), 0);
        chk("sim_level", int'(wr_level), 15);
        chk("sim_addr", int'(wr_addr), 1);

        // Wrap: read pointer trails the write count so write-side level settles at 4.
        w = 17;
        repeat (3) cyc(1'b0, 5'(to_gray(16)), 1'b0);
        chk("wrap_pre_level", int'(wr_level), 1);
        for (int i = 0; i < 40; i++) begin
            if (w % PMOD == 31) chk("wrap_gray_top", int'(wr_gray), 5'h10);
            cyc(1'b1, 5'(to_gray((w - 1) % PMOD)), 1'b0);
            w++;
            chk("wrap_no_full", int'(full), 0);
            chk("wrap_level", int'(wr_level), (i + 2 < 4) ? i + 2 : 4);
            if (w % PMOD == 0) chk("wrap_gray_zero", int'(wr_gray), 5'h00);
        end
        cyc(1'b0, 5'(to_gray((w - 1) % PMOD)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
